// File: rtl/load_unit_pkg.sv
// load_unit_pkg: shared definitions for the load sequencer.
//   - LD_* : load funct encodings (lb, lh, lw, lbu, lhu)
//   - state_t : 2-bit sequencer state encoding
//   - TIMEOUT_DEFAULT : default ack timeout in WAIT cycles
//   - ld_fault() : alignment / illegal-funct check on a command
package load_unit_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FAULT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // True when the command cannot be issued: unknown funct, odd
    // halfword address, or a word address that is not 4-byte aligned.
    function automatic logic ld_fault(input logic [2:0] f, input logic [1:0] a);
        case (f)
            LD_LB, LD_LBU: return 1'b0;
            LD_LH, LD_LHU: return a[0];
            LD_LW:         return (a != 2'b00);
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// load_unit_if: word-aligned memory read bus.
//   mem_req   : read request, held until the cycle mem_ack is seen
//   mem_addr  : word address (bits [1:0] always 00), stable while mem_req=1
//   mem_ack   : read data valid this cycle
//   mem_rdata : read word, little-endian
// Handshake: a transfer completes on the first rising edge where
// mem_req=1 and mem_ack=1; mem_ack with mem_req=0 is ignored.
interface load_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/extend.sv
// extend: sign- or zero-extends a WIDTH-bit value to 32 bits.
//   val_i  : value to extend
//   sext_i : 1 = replicate val_i[WIDTH-1], 0 = fill with zeros
//   ext_o  : 32-bit result
module extend #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             sext_i,
    output logic [31:0]      ext_o
);
    assign ext_o = {{(32-WIDTH){sext_i & val_i[WIDTH-1]}}, val_i};
endmodule

// File: rtl/load_align.sv
// load_align: combinational byte/halfword select and extension.
//   mem_rdata_i : memory word, little-endian
//   addr_lo_i   : byte offset within the word
//   funct_i     : load type (LD_* encodings)
//   value_o     : extended 32-bit load result
module load_align
    import load_unit_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct_i,
    output logic [31:0] value_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_ext;
    logic [31:0] half_ext;
    logic        sext;

    // Unsigned variants have funct[2] set.
    assign sext = ~funct_i[2];

    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = mem_rdata_i[7:0];
            2'd1: byte_sel = mem_rdata_i[15:8];
            2'd2: byte_sel = mem_rdata_i[23:16];
            2'd3: byte_sel = mem_rdata_i[31:24];
            default: byte_sel = mem_rdata_i[7:0];
        endcase
    end

    assign half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    extend #(.WIDTH(8)) u_ext_byte (
        .val_i  (byte_sel),
        .sext_i (sext),
        .ext_o  (byte_ext)
    );

    extend #(.WIDTH(16)) u_ext_half (
        .val_i  (half_sel),
        .sext_i (sext),
        .ext_o  (half_ext)
    );

    // funct[1:0]=00 is a byte load, 01 a halfword; lw passes through.
    always_comb begin
        value_o = half_ext;
        if (funct_i == LD_LW) begin
            value_o = mem_rdata_i;
        end else if (funct_i[1:0] == 2'b00) begin
            value_o = byte_ext;
        end
    end
endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle load sequencer between CPU control and memory.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : one-cycle command strobe, sampled only in IDLE
//   funct, addr   : load type and byte address
//   mem           : memory read bus (master side)
//   busy          : high in every state except IDLE
//   done          : one-cycle completion pulse
//   rdata         : extended load result
//   misalign      : alignment / illegal-funct fault, held until next start
//   timeout       : no mem_ack within TIMEOUT_CYCLES, held until next start
//   dbg_state_o   : current sequencer state
module load_unit
    import load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         funct,
    input  logic [31:0]        addr,
    load_unit_if.master        mem,
    output logic               busy,
    output logic               done,
    output logic [31:0]        rdata,
    output logic               misalign,
    output logic               timeout,
    output state_t             dbg_state_o
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        timeout_q;
    logic [7:0]  cnt_q;
    logic [2:0]  funct_q;
    logic [1:0]  addr_lo_q;

    logic [7:0]  cnt_d;
    logic [31:0] rdata_d;

    assign cnt_d = cnt_q + 8'd1;

    // Extraction works on the latched command so it is stable in WAIT.
    load_align u_align (
        .mem_rdata_i (mem.mem_rdata),
        .addr_lo_i   (addr_lo_q),
        .funct_i     (funct_q),
        .value_o     (rdata_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= 8'd0;
            funct_q    <= LD_LB;
            addr_lo_q  <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        funct_q    <= funct;
                        addr_lo_q  <= addr[1:0];
                        mem_addr_q <= {addr[31:2], 2'b00};
                        timeout_q  <= 1'b0;
                        cnt_q      <= 8'd0;
                        busy_q     <= 1'b1;
                        if (ld_fault(funct, addr[1:0])) begin
                            // Fault is reported in the very next cycle.
                            state_q    <= ST_FAULT;
                            misalign_q <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= ST_WAIT;
                            misalign_q <= 1'b0;
                            mem_req_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_ack) begin
                        rdata_q   <= rdata_d;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TO_LIMIT) begin
                            timeout_q <= 1'b1;
                            mem_req_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_FAULT, ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign misalign     = misalign_q;
    assign timeout      = timeout_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
  import load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata;

  load_unit_if mem_bus ();

  load_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .funct       (funct),
    .addr        (addr),
    .mem         (mem_bus),
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .misalign    (misalign),
    .timeout     (timeout),
    .dbg_state_o (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Legal load with ack after dly wait cycles; start driven at a negedge.
  task automatic run_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input int dly, input logic [31:0] exp);
    start = 1'b1; funct = f; addr = a;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = d;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".req"},   32'(mem_bus.mem_req), 32'd1);
    check({tag, ".maddr"}, mem_bus.mem_addr, {a[31:2], 2'b00});
    check({tag, ".busy"},  32'(busy), 32'd1);
    check({tag, ".to_clr"}, 32'(timeout), 32'd0);
    mem_bus.mem_ack = (dly == 0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({tag, ".wait_done"}, 32'(done), 32'd0);
      if (i == dly - 1) mem_bus.mem_ack = 1'b1;
    end
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check({tag, ".done"},  32'(done), 32'd1);
    check({tag, ".rdata"}, rdata, exp);
    check({tag, ".mis"},   32'(misalign), 32'd0);
    check({tag, ".req_off"}, 32'(mem_bus.mem_req), 32'd0);
    last_rdata = exp;
    @(negedge clk);
    check({tag, ".done_off"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic run_fault(input string tag, input logic [2:0] f, input logic [31:0] a);
    start = 1'b1; funct = f; addr = a;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".done"},  32'(done), 32'd1);
    check({tag, ".mis"},   32'(misalign), 32'd1);
    check({tag, ".req"},   32'(mem_bus.mem_req), 32'd0);
    check({tag, ".rdata"}, rdata, last_rdata);
    @(negedge clk);
    check({tag, ".done_off"}, 32'(done), 32'd0);
    check({tag, ".mis_hold"}, 32'(misalign), 32'd1);
    check({tag, ".req2"}, 32'(mem_bus.mem_req), 32'd0);
  endtask

  initial begin
    int ndone;
    int nreq;
    logic seen_done;

    // reset
    rst = 1'b1; start = 1'b0; funct = LD_LB; addr = 32'd0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'd0;
    last_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.req",   32'(mem_bus.mem_req), 32'd0);
    check("rst.maddr", mem_bus.mem_addr, 32'd0);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.mis",   32'(misalign), 32'd0);
    check("rst.to",    32'(timeout), 32'd0);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));

    // ack in IDLE is ignored
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    check("idle_ack.done", 32'(done), 32'd0);
    check("idle_ack.busy", 32'(busy), 32'd0);

    // data path, minimum latency, back-to-back
    run_load("lb",   LD_LB,  32'h0000_1003, 32'h8011_2233, 0, 32'hFFFF_FF80);
    run_load("lbu",  LD_LBU, 32'h0000_1003, 32'h8011_2233, 0, 32'h0000_0080);
    run_load("lhu",  LD_LHU, 32'h0000_1002, 32'hBEEF_1234, 0, 32'h0000_BEEF);
    run_load("lh",   LD_LH,  32'h0000_1002, 32'hBEEF_1234, 0, 32'hFFFF_BEEF);
    run_load("lb0",  LD_LB,  32'h0000_1000, 32'h8011_2233, 0, 32'h0000_0033);
    run_load("lb1",  LD_LB,  32'h0000_1001, 32'h8011_A233, 0, 32'hFFFF_FFA2);
    run_load("lb2",  LD_LBU, 32'h0000_1002, 32'h8011_2233, 0, 32'h0000_0011);
    run_load("lh0",  LD_LH,  32'h0000_1000, 32'h8011_9233, 0, 32'hFFFF_9233);
    run_load("lhu0", LD_LHU, 32'h0000_1000, 32'h8011_9233, 0, 32'h0000_9233);
    run_load("lw",   LD_LW,  32'h0000_2004, 32'h1234_5678, 2, 32'h1234_5678);

    // faults
    run_fault("lw_mis",  LD_LW,  32'h0000_2001);
    run_fault("f010",    3'b010, 32'h0000_2001);
    run_fault("f111",    3'b111, 32'h0000_2000);
    run_fault("lh_odd",  LD_LH,  32'h0000_2003);
    run_fault("lhu_odd", LD_LHU, 32'h0000_2001);

    // timeout
    start = 1'b1; funct = LD_LW; addr = 32'h0000_3000; mem_bus.mem_ack = 1'b0;
    nreq = 0; seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (mem_bus.mem_req) nreq++;
    end
    check("to.seen_done", 32'(seen_done), 32'd1);
    check("to.req_cycles", 32'(nreq), 32'd15);
    check("to.flag", 32'(timeout), 32'd1);
    check("to.mis",  32'(misalign), 32'd0);
    check("to.rdata", rdata, last_rdata);
    @(negedge clk);
    check("to.hold", 32'(timeout), 32'd1);
    // next start clears timeout (checked inside run_load)
    run_load("after_to", LD_LW, 32'h0000_3004, 32'h0BAD_F00D, 0, 32'h0BAD_F00D);

    // start during WAIT ignored, ack after 4 cycles
    start = 1'b1; funct = LD_LW; addr = 32'h0000_4000;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'hCAFE_F00D;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("wstart.rdata", rdata, 32'hCAFE_F00D);
        check("wstart.done_cyc", 32'(c), 32'd6);
      end
      if (c == 3) check("wstart.maddr", mem_bus.mem_addr, 32'h0000_4000);
      start = (c == 2);
      if (c == 2) begin
        funct = LD_LB; addr = 32'h0000_5001;
      end
      mem_bus.mem_ack = (c == 5);
    end
    check("wstart.ndone", 32'(ndone), 32'd1);
    check("wstart.idle", 32'(dbg_state), 32'(ST_IDLE));
    last_rdata = 32'hCAFE_F00D;
    // back-to-back pair
    run_load("b2b_a", LD_LW, 32'h0000_4004, 32'h1111_2222, 0, 32'h1111_2222);
    run_load("b2b_b", LD_LHU, 32'h0000_4006, 32'h8765_4321, 0, 32'h0000_8765);

    // reset in second WAIT cycle
    start = 1'b1; funct = LD_LW; addr = 32'h0000_6000; mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rmid.req_before", 32'(mem_bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rmid.req_async",  32'(mem_bus.mem_req), 32'd0);
    check("rmid.busy_async", 32'(busy), 32'd0);
    check("rmid.state",      32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0000_0123;
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      if (done) ndone++;
    end
    check("rmid.ndone", 32'(ndone), 32'd0);
    check("rmid.req",   32'(mem_bus.mem_req), 32'd0);
    check("rmid.rdata", rdata, 32'd0);
    check("rmid.idle",  32'(dbg_state), 32'(ST_IDLE));
    last_rdata = 32'd0;
    run_load("post_rst", LD_LB, 32'h0000_7002, 32'h00FE_0000, 1, 32'hFFFF_FFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global guard against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
